// File: rtl/f1_start_sequencer_if.sv
// Handshake between the start sequencer and the shared countdown delay block.
// The sequencer requests a delay of n_out cycles with trigger; the block answers with a time_out pulse.
interface f1_start_sequencer_if #(
    parameter int BIT_SZ = 14
);
    logic              trigger;
    logic [BIT_SZ-1:0] n_out;
    logic              time_out;

    modport master (output trigger, output n_out, input time_out);
    modport slave  (input trigger, input n_out, output time_out);
endinterface

// File: rtl/f1_start_sequencer.sv
// F1 reaction-timer sequencer: lights five start lights through the delay block,
// holds them for a random interval, then times the player's response after lights out.
module f1_start_sequencer #(
    parameter int BIT_SZ   = 14,
    parameter int STEP_N   = 500,
    parameter int MIN_RAND = 100
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  resp,
    input  logic [BIT_SZ-1:0]     rand_val,
    f1_start_sequencer_if.master  dly,
    output logic [4:0]            ledr,
    output logic [BIT_SZ-1:0]     react_time,
    output logic                  react_valid,
    output logic                  jump_start,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP  = 3'd1,
        S_GAP   = 3'd2,
        S_RAND  = 3'd3,
        S_COUNT = 3'd4,
        S_DONE  = 3'd5,
        S_FAULT = 3'd6
    } state_e;

    localparam logic [BIT_SZ-1:0] STEP_N_C   = BIT_SZ'(STEP_N);
    localparam logic [BIT_SZ-1:0] MIN_RAND_C = BIT_SZ'(MIN_RAND);
    localparam logic [BIT_SZ-1:0] CNT_MAX_C  = {BIT_SZ{1'b1}};

    function automatic logic [BIT_SZ-1:0] sat_inc(input logic [BIT_SZ-1:0] v);
        if (v == CNT_MAX_C) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(BIT_SZ-1){1'b0}}, 1'b1};
        end
    endfunction

    // Hold length is never below the clamp and never zero, even if the clamp is zero.
    function automatic logic [BIT_SZ-1:0] hold_len(input logic [BIT_SZ-1:0] r);
        logic [BIT_SZ-1:0] m;
        m = (r < MIN_RAND_C) ? MIN_RAND_C : r;
        if (m == {BIT_SZ{1'b0}}) begin
            hold_len = {{(BIT_SZ-1){1'b0}}, 1'b1};
        end else begin
            hold_len = m;
        end
    endfunction

    state_e            state_q, state_d;
    logic [2:0]        lit_q, lit_d;
    logic              gap_q, gap_d;
    logic [BIT_SZ-1:0] cnt_q, cnt_d;
    logic              trigger_q, trigger_d;
    logic [BIT_SZ-1:0] n_out_q, n_out_d;
    logic [4:0]        ledr_q, ledr_d;
    logic [BIT_SZ-1:0] react_time_q, react_time_d;
    logic              react_valid_q, react_valid_d;
    logic              jump_q, jump_d;
    logic              outstanding_q, outstanding_d;

    // Next-state and next-output computation for the sequencer FSM.
    always_comb begin
        state_d       = state_q;
        lit_d         = lit_q;
        gap_d         = gap_q;
        cnt_d         = cnt_q;
        trigger_d     = trigger_q;
        n_out_d       = n_out_q;
        ledr_d        = ledr_q;
        react_time_d  = react_time_q;
        react_valid_d = 1'b0;
        jump_d        = jump_q;

        case (state_q)
            S_IDLE: begin
                trigger_d = 1'b0;
                ledr_d    = 5'b00000;
                jump_d    = 1'b0;
                if (start) begin
                    state_d   = S_STEP;
                    lit_d     = 3'd0;
                    n_out_d   = STEP_N_C;
                    trigger_d = 1'b1;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_STEP: begin
                if (resp) begin
                    state_d   = S_FAULT;
                    trigger_d = 1'b0;
                    ledr_d    = 5'b11111;
                    jump_d    = 1'b1;
                end else if (dly.time_out) begin
                    state_d   = S_GAP;
                    trigger_d = 1'b0;
                    ledr_d    = ledr_q | (5'b00001 << lit_q);
                    lit_d     = lit_q + 3'd1;
                    gap_d     = 1'b0;
                end else begin
                    trigger_d = 1'b1;
                end
            end
            S_GAP: begin
                if (resp) begin
                    state_d   = S_FAULT;
                    trigger_d = 1'b0;
                    ledr_d    = 5'b11111;
                    jump_d    = 1'b1;
                end else if (!gap_q) begin
                    gap_d     = 1'b1;
                end else if (lit_q < 3'd5) begin
                    state_d   = S_STEP;
                    n_out_d   = STEP_N_C;
                    trigger_d = 1'b1;
                end else begin
                    state_d   = S_RAND;
                    n_out_d   = hold_len(rand_val);
                    trigger_d = 1'b1;
                end
            end
            S_RAND: begin
                if (resp) begin
                    state_d   = S_FAULT;
                    trigger_d = 1'b0;
                    ledr_d    = 5'b11111;
                    jump_d    = 1'b1;
                end else if (dly.time_out) begin
                    state_d   = S_COUNT;
                    trigger_d = 1'b0;
                    ledr_d    = 5'b00000;
                    cnt_d     = {BIT_SZ{1'b0}};
                end else begin
                    trigger_d = 1'b1;
                end
            end
            S_COUNT: begin
                // The counter already holds k once resp is seen k cycles after lights out.
                cnt_d = sat_inc(cnt_q);
                if (resp) begin
                    state_d       = S_DONE;
                    react_time_d  = cnt_d;
                    react_valid_d = 1'b1;
                end else begin
                    state_d       = S_COUNT;
                end
            end
            S_DONE: begin
                ledr_d = 5'b00000;
                if (!start && !resp) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_FAULT: begin
                trigger_d = 1'b0;
                ledr_d    = 5'b11111;
                jump_d    = 1'b1;
                if (!start && !resp && !outstanding_q) begin
                    state_d = S_IDLE;
                    ledr_d  = 5'b00000;
                    jump_d  = 1'b0;
                end else begin
                    state_d = S_FAULT;
                end
            end
            default: begin
                state_d   = S_IDLE;
                trigger_d = 1'b0;
                ledr_d    = 5'b00000;
                jump_d    = 1'b0;
                lit_d     = 3'd0;
            end
        endcase

        // A fresh request takes precedence over a stray completion arriving on the same edge.
        if (trigger_d && !trigger_q) begin
            outstanding_d = 1'b1;
        end else if (dly.time_out) begin
            outstanding_d = 1'b0;
        end else begin
            outstanding_d = outstanding_q;
        end
    end

    // State and output registers.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            lit_q         <= 3'd0;
            gap_q         <= 1'b0;
            cnt_q         <= {BIT_SZ{1'b0}};
            trigger_q     <= 1'b0;
            n_out_q       <= {BIT_SZ{1'b0}};
            ledr_q        <= 5'b00000;
            react_time_q  <= {BIT_SZ{1'b0}};
            react_valid_q <= 1'b0;
            jump_q        <= 1'b0;
            outstanding_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lit_q         <= lit_d;
            gap_q         <= gap_d;
            cnt_q         <= cnt_d;
            trigger_q     <= trigger_d;
            n_out_q       <= n_out_d;
            ledr_q        <= ledr_d;
            react_time_q  <= react_time_d;
            react_valid_q <= react_valid_d;
            jump_q        <= jump_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign dly.trigger = trigger_q;
    assign dly.n_out   = n_out_q;
    assign ledr        = ledr_q;
    assign react_time  = react_time_q;
    assign react_valid = react_valid_q;
    assign jump_start  = jump_q;
    assign state       = state_q;

endmodule

// File: tb/tb_f1_start_sequencer.sv
// Directed bench for f1_start_sequencer with a behavioural delay-block model.
module tb_f1_start_sequencer;

    localparam int BIT_SZ = 14;

    logic              sysclk = 1'b0;
    logic              rst;
    logic              start;
    logic              resp;
    logic [BIT_SZ-1:0] rand_val;
    logic [4:0]        ledr;
    logic [BIT_SZ-1:0] react_time;
    logic              react_valid;
    logic              jump_start;
    logic [2:0]        state;

    logic model_en;
    logic model_to;
    logic man_to;
    logic busy;
    logic wait_low;
    int   cnt;

    int checks = 0;
    int errors = 0;

    f1_start_sequencer_if #(.BIT_SZ(BIT_SZ)) dif ();

    f1_start_sequencer #(.BIT_SZ(BIT_SZ), .STEP_N(4), .MIN_RAND(100)) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .start       (start),
        .resp        (resp),
        .rand_val    (rand_val),
        .dly         (dif),
        .ledr        (ledr),
        .react_time  (react_time),
        .react_valid (react_valid),
        .jump_start  (jump_start),
        .state       (state)
    );

    always #5 sysclk = ~sysclk;

    assign dif.time_out = model_to | man_to;

    // Delay model: time_out pulses about N+1 cycles after trigger, re-arms once trigger drops.
    always @(posedge sysclk or posedge rst) begin
        if (rst) begin
            model_to <= 1'b0; busy <= 1'b0; wait_low <= 1'b0; cnt <= 0;
        end else if (!model_en) begin
            model_to <= 1'b0; busy <= 1'b0; wait_low <= 1'b0; cnt <= 0;
        end else begin
            model_to <= 1'b0;
            if (wait_low) begin
                if (!dif.trigger) wait_low <= 1'b0;
            end else if (busy) begin
                if (cnt == 0) begin
                    model_to <= 1'b1; busy <= 1'b0; wait_low <= 1'b1;
                end else begin
                    cnt <= cnt - 1;
                end
            end else if (dif.trigger) begin
                busy <= 1'b1;
                cnt  <= int'(dif.n_out);
            end
        end
    end

    typedef struct {
        int rand_v;
        int exp_n;
        int k;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input int target, input int budget, input string name);
        int n = 0;
        while (int'(state) != target && n < budget) begin
            tick();
            n++;
        end
        check(name, int'(state), target);
    endtask

    task automatic do_run(input int rv, input int exp_n, input int k, input int exp_react, input string tag);
        check({tag, "_idle"}, int'(state), 0);
        rand_val = BIT_SZ'(rv);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_step_state"}, int'(state), 1);
        check({tag, "_step_trig"}, int'(dif.trigger), 1);
        check({tag, "_step_n"}, int'(dif.n_out), 4);
        for (int i = 1; i <= 5; i++) begin
            wait_state(2, 50, $sformatf("%s_gap%0d", tag, i));
            check($sformatf("%s_ledr%0d", tag, i), int'(ledr), (1 << i) - 1);
            check($sformatf("%s_gaptrig%0d_a", tag, i), int'(dif.trigger), 0);
            tick();
            check($sformatf("%s_gap%0d_b", tag, i), int'(state), 2);
            check($sformatf("%s_gaptrig%0d_b", tag, i), int'(dif.trigger), 0);
            tick();
            if (i < 5) begin
                check($sformatf("%s_restep%0d", tag, i), int'(state), 1);
                check($sformatf("%s_restep_n%0d", tag, i), int'(dif.n_out), 4);
            end else begin
                check({tag, "_rand_state"}, int'(state), 3);
                check({tag, "_rand_n"}, int'(dif.n_out), exp_n);
            end
            check($sformatf("%s_retrig%0d", tag, i), int'(dif.trigger), 1);
        end
        wait_state(4, exp_n + 20, {tag, "_count"});
        check({tag, "_lights_out"}, int'(ledr), 0);
        check({tag, "_count_trig"}, int'(dif.trigger), 0);
        repeat (k - 1) tick();
        resp = 1'b1;
        tick();
        check({tag, "_react_time"}, int'(react_time), exp_react);
        check({tag, "_react_valid"}, int'(react_valid), 1);
        check({tag, "_done"}, int'(state), 5);
        resp = 1'b0;
        tick();
        check({tag, "_valid_pulse"}, int'(react_valid), 0);
        check({tag, "_back_idle"}, int'(state), 0);
        check({tag, "_react_held"}, int'(react_time), exp_react);
    endtask

    initial begin
        vecs[0] = '{rand_v: 200,  exp_n: 200,  k: 37};
        vecs[1] = '{rand_v: 5,    exp_n: 100,  k: 1};
        vecs[2] = '{rand_v: 0,    exp_n: 100,  k: 12};
        vecs[3] = '{rand_v: 101,  exp_n: 101,  k: 3};
        vecs[4] = '{rand_v: 100,  exp_n: 100,  k: 5};
        vecs[5] = '{rand_v: 1000, exp_n: 1000, k: 250};

        rst = 1'b1; start = 1'b0; resp = 1'b0; rand_val = '0;
        model_en = 1'b1; man_to = 1'b0;
        #12;
        check("rst_state", int'(state), 0);
        check("rst_trigger", int'(dif.trigger), 0);
        check("rst_n_out", int'(dif.n_out), 0);
        check("rst_ledr", int'(ledr), 0);
        check("rst_react_time", int'(react_time), 0);
        check("rst_react_valid", int'(react_valid), 0);
        check("rst_jump", int'(jump_start), 0);
        #3 rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            do_run(vecs[v].rand_v, vecs[v].exp_n, vecs[v].k, vecs[v].k, $sformatf("vec%0d", v));
        end

        do_run(100, 100, 20000, 16383, "sat");

        // Jump start during the third gap.
        rand_val = 14'd200;
        start = 1'b1; tick(); start = 1'b0;
        begin
            int n = 0;
            while (!(ledr == 5'b00111 && state == 3'd2) && n < 200) begin tick(); n++; end
        end
        check("js_gap3", int'(state), 2);
        resp = 1'b1; tick();
        check("js_state", int'(state), 6);
        check("js_ledr", int'(ledr), 31);
        check("js_flag", int'(jump_start), 1);
        check("js_trig", int'(dif.trigger), 0);
        check("js_react_kept", int'(react_time), 16383);
        resp = 1'b0; tick();
        check("js_release_idle", int'(state), 0);
        check("js_release_flag", int'(jump_start), 0);
        check("js_release_ledr", int'(ledr), 0);

        // Abort during the hold with the delay still outstanding.
        start = 1'b1; tick(); start = 1'b0;
        wait_state(3, 300, "fo_rand");
        model_en = 1'b0;
        resp = 1'b1; tick();
        check("fo_fault", int'(state), 6);
        check("fo_trig", int'(dif.trigger), 0);
        resp = 1'b0;
        repeat (5) tick();
        check("fo_wait_to", int'(state), 6);
        check("fo_wait_flag", int'(jump_start), 1);
        man_to = 1'b1; tick(); man_to = 1'b0;
        check("fo_to_edge", int'(state), 6);
        tick();
        check("fo_idle", int'(state), 0);

        // resp and time_out on the same edge in RAND: fault wins, outstanding clears.
        model_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        wait_state(3, 300, "pr_rand");
        model_en = 1'b0;
        resp = 1'b1; man_to = 1'b1; tick();
        resp = 1'b0; man_to = 1'b0;
        check("pr_fault", int'(state), 6);
        check("pr_ledr", int'(ledr), 31);
        tick();
        check("pr_idle", int'(state), 0);

        // Asynchronous reset in the middle of the hold.
        model_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        wait_state(3, 300, "ar_rand");
        #4 rst = 1'b1;
        #1;
        check("ar_state", int'(state), 0);
        check("ar_trigger", int'(dif.trigger), 0);
        check("ar_n_out", int'(dif.n_out), 0);
        check("ar_ledr", int'(ledr), 0);
        check("ar_react_time", int'(react_time), 0);
        check("ar_jump", int'(jump_start), 0);
        check("ar_valid", int'(react_valid), 0);
        #7 rst = 1'b0;
        tick();
        do_run(200, 200, 37, 37, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/f1_start_sequencer.md
# f1_start_sequencer

Sequencer for the F1 reaction-timer challenge. It drives the shared countdown delay block through its trigger/N/time_out handshake to light the five start lights one per fixed interval. It then holds all five lit for a random interval, blanks them ("lights out") and measures the player's reaction time in clock cycles. It also detects jump starts and keeps the delay block consistent when a run is aborted.

## Interface
Parameters:
- BIT_SZ, 14, width of delay count and reaction counter
- STEP_N, 500, delay N per start light (cycles)
- MIN_RAND, 100, lower clamp on random hold interval

Ports:
- sysclk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  player start button, level
- resp  in  1  player response button, level
- rand_val  in  BIT_SZ  free-running random value
- time_out  in  1  delay block done, one-cycle pulse
- trigger  out  1  delay block trigger, registered
- n_out  out  BIT_SZ  delay count N, registered, stable while trigger=1
- ledr  out  5  start lights
- react_time  out  BIT_SZ  last reaction time, held
- react_valid  out  1  one-cycle pulse when react_time updates
- jump_start  out  1  held high while in FAULT
- state  out  3  current FSM state, for debug LEDs

## Operation
- States: IDLE=0, STEP=1, GAP=2, RAND=3, COUNT=4, DONE=5, FAULT=6.
- IDLE: trigger=0, ledr=0. start=1 → STEP, lit=0, n_out=STEP_N, trigger=1.
- STEP: trigger held 1 until time_out=1 is sampled. That edge: trigger←0, lit←lit+1, ledr[lit]←1 (lights fill LSB first), → GAP, gap counter=0.
- GAP: trigger=0 for exactly 2 cycles, which lets the delay block return to its idle state. Then:
  - lit<5 → STEP (trigger=1, n_out=STEP_N).
  - lit=5 → RAND. rand_val is sampled on that edge; n_out = max(rand_val, MIN_RAND), forced ≥1. trigger=1.
- RAND: on time_out: trigger←0, ledr←0, reaction counter←0, → COUNT.
- COUNT: counter +1 per cycle, saturating at 2^BIT_SZ−1. resp=1 → react_time←counter, react_valid=1 for one cycle, → DONE.
- DONE: ledr=0. start=0 and resp=0 → IDLE.
- Jump start: resp=1 in STEP, GAP or RAND → FAULT. Entry: trigger←0, ledr←5'b11111, jump_start←1. react_time is unchanged.
- Outstanding flag: set when trigger rises, cleared on time_out. FAULT → IDLE only when start=0, resp=0 and outstanding=0. A stray time_out from an aborted delay must never be consumed by a later run.
- time_out outside STEP/RAND only clears outstanding; it has no other effect.
- Priority in STEP/RAND when resp=1 and time_out=1 in the same cycle: jump start wins (→ FAULT), outstanding clears.
- Reset (any time, mid-run included): state=IDLE, trigger=0, n_out=0, ledr=0, react_time=0, react_valid=0, jump_start=0, lit=0, outstanding=0, counters=0.

## Timing
- All outputs are registered; no combinational input→output paths.
- trigger rises on the edge after start=1 is sampled in IDLE.
- trigger falls on the edge that samples time_out=1. The trigger low gap between consecutive requests is ≥2 cycles.
- Lights out (ledr→0) and the reaction counter clear happen on the same edge. resp sampled k cycles after that edge gives react_time=k (k≥1).
- react_valid is asserted in the cycle after the resp sample, for 1 cycle.
- n_out changes only on the edge where trigger rises.

## Test plan
- Normal run, STEP_N=4, rand_val=200, bench delay model returns time_out N+1 cycles after trigger: ledr goes 00001→…→11111, n_out=200 for the hold, ledr=0, then resp 37 cycles later → react_time=37, react_valid single pulse, state=DONE.
- Random clamp: rand_val=5, MIN_RAND=100 → n_out=100. rand_val=0 → n_out=100.
- Jump start: resp=1 during 3rd GAP → state=FAULT, ledr=11111, jump_start=1, trigger=0. Late time_out clears outstanding; release buttons → IDLE, jump_start=0.
- FAULT with delay outstanding: start/resp released before time_out → state stays FAULT until the time_out pulse, then IDLE next edge.
- Saturation: no resp for 20000 cycles after lights out → react_time=16383 on resp.
- Async reset asserted mid-RAND, not aligned to sysclk → all outputs 0 immediately, state=0. Release → a new start begins a clean run.
